ff4_wb: RTL and testbench

Final writeback stage of the SPU dual-issue pipeline. It consumes the even/odd results, local-store address and branch information registered by FF3, and drives the two register-file write ports. It also drives the local-store quadword address, the fetch-redirect request and a committed-write counter. Same-cycle write collisions are resolved here, and younger instructions after a taken branch are squashed through a small delay-slot/flush state machine.

---
 rtl/ff4_wb_pkg.sv | 18 +
 rtl/wb_redirect_fsm.sv | 79 +++++++
 rtl/ff4_wb.sv | 99 +++++++++
 tb/tb_ff4_wb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ff4_wb_pkg.sv
// Shared widths, reset polarity and writeback FSM encodings for the ff4_wb
// writeback stage and its redirect/flush controller.
package ff4_wb_pkg;

    localparam int REG_ADDR_BUS7 = 7;
    localparam int REG_BUS128    = 128;
    localparam int UID_W         = 3;
    localparam int PC_W          = 32;

    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_DSLOT = 2'd1,
        WB_FLUSH = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_redirect_fsm.sv
// Branch redirect and delay-slot/flush controller for the writeback stage:
// issues the redirect pulse and tells the datapath which pairs to squash.
module wb_redirect_fsm
    import ff4_wb_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch_flag,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] link_addr,
    output logic            squash,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] redirect_link
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    wb_state_e  state, state_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;
    logic       take_branch;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state     <= WB_IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        unique case (state)
            WB_IDLE: begin
                if (branch_flag) state_nxt = WB_DSLOT;
            end
            WB_DSLOT: begin
                state_nxt     = WB_FLUSH;
                flush_cnt_nxt = FLUSH_LOAD;
            end
            WB_FLUSH: begin
                flush_cnt_nxt = flush_cnt - 3'd1;
                if (flush_cnt == 3'd1) state_nxt = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    // Branches are only honoured from IDLE; delay-slot and flushed branches
    // never reach the redirect logic.
    always_comb begin
        take_branch = (state == WB_IDLE) && branch_flag;
        squash      = (state == WB_FLUSH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            redirect      <= 1'b0;
            redirect_pc   <= '0;
            redirect_link <= '0;
        end else begin
            redirect <= take_branch;
            if (take_branch) begin
                redirect_pc   <= branch_target;
                redirect_link <= link_addr;
            end
        end
    end

endmodule

// File: rtl/ff4_wb.sv
// Final writeback stage of the SPU dual-issue pipeline: squashes flushed
// pairs, resolves same-register collisions and counts committed writes.
module ff4_wb
    import ff4_wb_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int LS_QW_W      = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_ADDR_BUS7-1:0] iwb_rtaddr_e,
    input  logic [REG_ADDR_BUS7-1:0] iwb_rtaddr_o,
    input  logic                     iwb_wreg_e,
    input  logic                     iwb_wreg_o,
    input  logic [REG_BUS128-1:0]    iwb_rt_e,
    input  logic [REG_BUS128-1:0]    iwb_rt_o,
    input  logic [UID_W-1:0]         iwb_uid_e,
    input  logic [UID_W-1:0]         iwb_uid_o,
    input  logic [0:31]              iwb_memory_addr_o,
    input  logic                     iwb_branch_flag,
    input  logic [PC_W-1:0]          iwb_branch_target_addr,
    input  logic [PC_W-1:0]          iwb_link_addr,
    input  logic                     iwb_is_in_delayslot,
    output logic                     wb_we_e,
    output logic                     wb_we_o,
    output logic [REG_ADDR_BUS7-1:0] wb_waddr_e,
    output logic [REG_ADDR_BUS7-1:0] wb_waddr_o,
    output logic [REG_BUS128-1:0]    wb_wdata_e,
    output logic [REG_BUS128-1:0]    wb_wdata_o,
    output logic [UID_W-1:0]         wb_uid_e,
    output logic [UID_W-1:0]         wb_uid_o,
    output logic [LS_QW_W-1:0]       wb_ls_qw,
    output logic                     wb_redirect,
    output logic [PC_W-1:0]          wb_redirect_pc,
    output logic [PC_W-1:0]          wb_redirect_link,
    output logic                     wb_flushing,
    output logic [31:0]              wb_commit_cnt
);

    logic squash;
    logic we_e_nxt, we_o_nxt;
    logic unused;

    // The delay-slot marker is tracked by the FSM itself; the address bits
    // outside the quadword index carry no meaning here.
    assign unused = ^{iwb_is_in_delayslot,
                      iwb_memory_addr_o[0:27-LS_QW_W],
                      iwb_memory_addr_o[28:31]};

    wb_redirect_fsm #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_redirect_fsm (
        .clk           (clk),
        .rst           (rst),
        .branch_flag   (iwb_branch_flag),
        .branch_target (iwb_branch_target_addr),
        .link_addr     (iwb_link_addr),
        .squash        (squash),
        .redirect      (wb_redirect),
        .redirect_pc   (wb_redirect_pc),
        .redirect_link (wb_redirect_link)
    );

    // The odd pipe holds the younger instruction, so it wins a same-register
    // collision and the even write is dropped.
    assign we_o_nxt = iwb_wreg_o & ~squash;
    assign we_e_nxt = iwb_wreg_e & ~squash &
                      ~(we_o_nxt & (iwb_rtaddr_e == iwb_rtaddr_o));

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            wb_we_e       <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_waddr_e    <= '0;
            wb_waddr_o    <= '0;
            wb_wdata_e    <= '0;
            wb_wdata_o    <= '0;
            wb_uid_e      <= '0;
            wb_uid_o      <= '0;
            wb_ls_qw      <= '0;
            wb_flushing   <= 1'b0;
            wb_commit_cnt <= '0;
        end else begin
            wb_we_e       <= we_e_nxt;
            wb_we_o       <= we_o_nxt;
            wb_waddr_e    <= iwb_rtaddr_e;
            wb_waddr_o    <= iwb_rtaddr_o;
            wb_wdata_e    <= iwb_rt_e;
            wb_wdata_o    <= iwb_rt_o;
            wb_uid_e      <= iwb_uid_e;
            wb_uid_o      <= iwb_uid_o;
            // Big-endian bit numbering: [14:27] is the quadword index.
            wb_ls_qw      <= iwb_memory_addr_o[28-LS_QW_W:27];
            wb_flushing   <= squash;
            wb_commit_cnt <= wb_commit_cnt + {31'd0, we_e_nxt} + {31'd0, we_o_nxt};
        end
    end

endmodule

// File: tb/tb_ff4_wb.sv
// Scoreboard bench for ff4_wb: directed pairs push their expected writeback
// response; a monitor pops and compares one entry after every clock edge.
module tb_ff4_wb;

    localparam int LS_QW_W = 14;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [6:0]   iwb_rtaddr_e, iwb_rtaddr_o;
    logic         iwb_wreg_e, iwb_wreg_o;
    logic [127:0] iwb_rt_e, iwb_rt_o;
    logic [2:0]   iwb_uid_e, iwb_uid_o;
    logic [0:31]  iwb_memory_addr_o;
    logic         iwb_branch_flag;
    logic [31:0]  iwb_branch_target_addr, iwb_link_addr;
    logic         iwb_is_in_delayslot;

    logic         wb_we_e, wb_we_o;
    logic [6:0]   wb_waddr_e, wb_waddr_o;
    logic [127:0] wb_wdata_e, wb_wdata_o;
    logic [2:0]   wb_uid_e, wb_uid_o;
    logic [13:0]  wb_ls_qw;
    logic         wb_redirect;
    logic [31:0]  wb_redirect_pc, wb_redirect_link;
    logic         wb_flushing;
    logic [31:0]  wb_commit_cnt;

    ff4_wb #(.FLUSH_CYCLES(2), .LS_QW_W(LS_QW_W)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .iwb_rtaddr_e           (iwb_rtaddr_e),
        .iwb_rtaddr_o           (iwb_rtaddr_o),
        .iwb_wreg_e             (iwb_wreg_e),
        .iwb_wreg_o             (iwb_wreg_o),
        .iwb_rt_e               (iwb_rt_e),
        .iwb_rt_o               (iwb_rt_o),
        .iwb_uid_e              (iwb_uid_e),
        .iwb_uid_o              (iwb_uid_o),
        .iwb_memory_addr_o      (iwb_memory_addr_o),
        .iwb_branch_flag        (iwb_branch_flag),
        .iwb_branch_target_addr (iwb_branch_target_addr),
        .iwb_link_addr          (iwb_link_addr),
        .iwb_is_in_delayslot    (iwb_is_in_delayslot),
        .wb_we_e                (wb_we_e),
        .wb_we_o                (wb_we_o),
        .wb_waddr_e             (wb_waddr_e),
        .wb_waddr_o             (wb_waddr_o),
        .wb_wdata_e             (wb_wdata_e),
        .wb_wdata_o             (wb_wdata_o),
        .wb_uid_e               (wb_uid_e),
        .wb_uid_o               (wb_uid_o),
        .wb_ls_qw               (wb_ls_qw),
        .wb_redirect            (wb_redirect),
        .wb_redirect_pc         (wb_redirect_pc),
        .wb_redirect_link       (wb_redirect_link),
        .wb_flushing            (wb_flushing),
        .wb_commit_cnt          (wb_commit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we_e, we_o;
        logic [6:0]   wa_e, wa_o;
        logic [127:0] wd_e, wd_o;
        logic [2:0]   uid_e, uid_o;
        logic [13:0]  qw;
        logic         redirect, flushing;
        logic [31:0]  pc, link, cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_cnt  = 32'd0;
    logic [31:0] exp_pc   = 32'd0;
    logic [31:0] exp_link = 32'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic set_idle();
        iwb_rtaddr_e = 7'd0;  iwb_rtaddr_o = 7'd0;
        iwb_wreg_e = 1'b0;    iwb_wreg_o = 1'b0;
        iwb_rt_e = 128'd0;    iwb_rt_o = 128'd0;
        iwb_uid_e = 3'd0;     iwb_uid_o = 3'd0;
        iwb_memory_addr_o = 32'd0;
        iwb_branch_flag = 1'b0;
        iwb_branch_target_addr = 32'd0;
        iwb_link_addr = 32'd0;
        iwb_is_in_delayslot = 1'b0;
    endtask

    // Applies one pair at a negedge, pushes its hand-computed response and
    // returns at the following negedge (after the DUT has sampled it).
    task automatic drive(
        input logic [6:0] ae, input logic req_e, input logic [6:0] ao, input logic req_o,
        input logic [127:0] d_e, input logic [127:0] d_o, input logic [31:0] mem,
        input logic br, input logic [31:0] tgt, input logic [31:0] lnk,
        input logic x_we_e, input logic x_we_o, input logic x_redir, input logic x_flush,
        input logic [13:0] x_qw);
        exp_t e;
        iwb_rtaddr_e = ae;   iwb_wreg_e = req_e;  iwb_rt_e = d_e;  iwb_uid_e = ae[2:0];
        iwb_rtaddr_o = ao;   iwb_wreg_o = req_o;  iwb_rt_o = d_o;  iwb_uid_o = ~ao[2:0];
        iwb_memory_addr_o = mem;
        iwb_branch_flag = br;
        iwb_branch_target_addr = tgt;
        iwb_link_addr = lnk;
        iwb_is_in_delayslot = 1'b0;
        if (x_redir) begin
            exp_pc   = tgt;
            exp_link = lnk;
        end
        exp_cnt = exp_cnt + 32'(x_we_e) + 32'(x_we_o);
        e.we_e = x_we_e;  e.we_o = x_we_o;
        e.wa_e = ae;      e.wa_o = ao;
        e.wd_e = d_e;     e.wd_o = d_o;
        e.uid_e = ae[2:0]; e.uid_o = ~ao[2:0];
        e.qw = x_qw;
        e.redirect = x_redir;
        e.flushing = x_flush;
        e.pc = exp_pc;  e.link = exp_link;  e.cnt = exp_cnt;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the stage presents a new result after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("we_e",     128'(wb_we_e),          128'(e.we_e));
                check("we_o",     128'(wb_we_o),          128'(e.we_o));
                check("waddr_e",  128'(wb_waddr_e),       128'(e.wa_e));
                check("waddr_o",  128'(wb_waddr_o),       128'(e.wa_o));
                check("wdata_e",  wb_wdata_e,             e.wd_e);
                check("wdata_o",  wb_wdata_o,             e.wd_o);
                check("uid_e",    128'(wb_uid_e),         128'(e.uid_e));
                check("uid_o",    128'(wb_uid_o),         128'(e.uid_o));
                check("ls_qw",    128'(wb_ls_qw),         128'(e.qw));
                check("redirect", 128'(wb_redirect),      128'(e.redirect));
                check("flushing", 128'(wb_flushing),      128'(e.flushing));
                check("rd_pc",    128'(wb_redirect_pc),   128'(e.pc));
                check("rd_link",  128'(wb_redirect_link), 128'(e.link));
                check("commit",   128'(wb_commit_cnt),    128'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DB = 128'hBBBB_1001_BBBB_1002_BBBB_1003_BBBB_1004;

    initial begin
        int waited;
        set_idle();
        rst = 1'b0;
        #6;
        check("rst_we_e",     128'(wb_we_e),        128'd0);
        check("rst_we_o",     128'(wb_we_o),        128'd0);
        check("rst_redirect", 128'(wb_redirect),    128'd0);
        check("rst_flushing", 128'(wb_flushing),    128'd0);
        check("rst_commit",   128'(wb_commit_cnt),  128'd0);
        check("rst_pc",       128'(wb_redirect_pc), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        //    ae   re    ao   ro    d_e  d_o  mem            br   tgt           lnk           we_e we_o rdr  fl   qw
        // independent writes, collision, single write to same reg
        drive(7'd5, 1'b1, 7'd9,  1'b1, DA, DB, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0);
        drive(7'd12,1'b1, 7'd12, 1'b1, 128'd1, 128'd2, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 14'h0);
        drive(7'd7, 1'b1, 7'd7,  1'b0, DB, DA, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0);
        // local-store index, top of range and wrap past 256 KB
        drive(7'd1, 1'b1, 7'd2,  1'b1, DA, DA, 32'h0003_FFF0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h3FFF);
        drive(7'd3, 1'b0, 7'd4,  1'b0, DB, DB, 32'h0004_0005, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000);
        // taken branch, branching delay slot, branches while flushing
        drive(7'd10,1'b1, 7'd11, 1'b1, DA, DB, 32'h0, 1'b1, 32'h0000_0400, 32'h0000_0108, 1'b1, 1'b1, 1'b1, 1'b0, 14'h0);
        drive(7'd14,1'b1, 7'd15, 1'b1, DB, DA, 32'h0, 1'b1, 32'h0000_0800, 32'h0000_010C, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0);
        drive(7'd16,1'b1, 7'd17, 1'b1, DA, DB, 32'h0, 1'b1, 32'h0000_0900, 32'h0000_0110, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        drive(7'd18,1'b1, 7'd19, 1'b1, DB, DA, 32'h0, 1'b1, 32'h0000_0A00, 32'h0000_0114, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        drive(7'd20,1'b1, 7'd21, 1'b1, DA, DB, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0);

        // filler commits so the counter sits at 37 in the later flush
        for (int i = 0; exp_cnt < 32'd29; i++) begin
            if (32'd29 - exp_cnt >= 32'd2)
                drive(7'(30 + 2*i), 1'b1, 7'(31 + 2*i), 1'b1, {4{32'(i)}}, ~{4{32'(i)}}, 32'h0,
                      1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0);
            else
                drive(7'(30 + 2*i), 1'b1, 7'(31 + 2*i), 1'b0, {4{32'(i)}}, ~{4{32'(i)}}, 32'h0,
                      1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0);
        end

        // second branch, then a branch in the first IDLE cycle after flush
        drive(7'd50,1'b1, 7'd51, 1'b1, DA, DB, 32'h0, 1'b1, 32'h0000_2000, 32'h0000_1004, 1'b1, 1'b1, 1'b1, 1'b0, 14'h0);
        drive(7'd52,1'b1, 7'd53, 1'b1, DB, DA, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0);
        drive(7'd54,1'b1, 7'd55, 1'b1, DA, DB, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        drive(7'd56,1'b1, 7'd57, 1'b1, DB, DA, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        drive(7'd58,1'b1, 7'd59, 1'b1, DA, DB, 32'h0, 1'b1, 32'h0000_3000, 32'h0000_2008, 1'b1, 1'b1, 1'b1, 1'b0, 14'h0);
        drive(7'd60,1'b1, 7'd61, 1'b1, DB, DA, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0);
        drive(7'd62,1'b1, 7'd63, 1'b1, DA, DB, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);

        // asynchronous reset in the middle of FLUSH
        check("cnt_pre_rst",   128'(wb_commit_cnt), 128'd37);
        check("flush_pre_rst", 128'(wb_flushing),   128'd1);
        #1 rst = 1'b0;
        set_idle();
        #1;
        check("mid_rst_we_e",     128'(wb_we_e),          128'd0);
        check("mid_rst_we_o",     128'(wb_we_o),          128'd0);
        check("mid_rst_flushing", 128'(wb_flushing),      128'd0);
        check("mid_rst_commit",   128'(wb_commit_cnt),    128'd0);
        check("mid_rst_pc",       128'(wb_redirect_pc),   128'd0);
        check("mid_rst_link",     128'(wb_redirect_link), 128'd0);
        check("mid_rst_wdata_o",  wb_wdata_o,             128'd0);
        check("mid_rst_waddr_e",  128'(wb_waddr_e),       128'd0);
        #1 rst = 1'b1;
        exp_cnt  = 32'd0;
        exp_pc   = 32'd0;
        exp_link = 32'd0;
        drive(7'd0, 1'b0, 7'd0, 1'b0, 128'd0, 128'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0);

        // FSM back in IDLE: a fresh branch redirects with the full flush
        drive(7'd70,1'b1, 7'd71, 1'b1, DA, DB, 32'h0, 1'b1, 32'h0000_4000, 32'h0000_3004, 1'b1, 1'b1, 1'b1, 1'b0, 14'h0);
        drive(7'd72,1'b1, 7'd73, 1'b1, DB, DA, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0);
        drive(7'd74,1'b1, 7'd75, 1'b1, DA, DB, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        drive(7'd76,1'b1, 7'd77, 1'b1, DB, DA, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0);
        drive(7'd78,1'b1, 7'd79, 1'b1, DA, DB, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0);
        set_idle();

        waited = 0;
        while (sb_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        check("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
